// File: rtl/float_div_seq.sv
// Iterative binary32 divider Y = A / B: restoring division (one quotient bit per cycle), then normalise and round to nearest-even.
// Latency 27 cycles (special operands 1); operands accepted only in IDLE, result held until out_ready.
module float_div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Y
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_DONE} state_t;

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [25:0]        r_q;
  logic [24:0]        r_rem;
  logic [23:0]        r_mb;
  logic               r_spec;
  logic [31:0]        r_spec_y;
  logic [31:0]        r_y;
  logic               r_out_valid;

  logic               w_a_nan, w_a_inf, w_a_zero;
  logic               w_b_nan, w_b_inf, w_b_zero;
  logic               w_sign;
  logic               w_spec;
  logic [31:0]        w_spec_y;

  assign w_sign   = A[31] ^ B[31];
  // Denormals (exp == 0) are classified as zero.
  assign w_a_zero = (A[30:23] == 8'h00);
  assign w_b_zero = (B[30:23] == 8'h00);
  assign w_a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'h0);
  assign w_b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'h0);
  assign w_a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'h0);
  assign w_b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'h0);

  always_comb begin
    w_spec   = 1'b0;
    w_spec_y = 32'h0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec   = 1'b1;
      w_spec_y = 32'h7FC00000;
    end else if (w_a_inf || w_b_zero) begin
      w_spec   = 1'b1;
      w_spec_y = {w_sign, 8'hFF, 23'h0};
    end else if (w_a_zero || w_b_inf) begin
      w_spec   = 1'b1;
      w_spec_y = {w_sign, 31'h0};
    end
  end

  logic               w_ge;
  logic [24:0]        w_diff;
  logic [24:0]        w_rem_nxt;

  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_diff    = r_rem - {1'b0, r_mb};
  assign w_rem_nxt = w_ge ? {w_diff[23:0], 1'b0} : {r_rem[23:0], 1'b0};

  logic [23:0]        w_m;
  logic               w_guard, w_sticky, w_rnd;
  logic signed [9:0]  w_e_adj, w_e_fin;
  logic [24:0]        w_m_sum;
  logic [23:0]        w_m_fin;
  logic [31:0]        w_norm_y;

  always_comb begin
    if (r_q[25]) begin
      w_m      = r_q[25:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] | (r_rem != 25'h0);
      w_e_adj  = r_exp;
    end else begin
      w_m      = r_q[24:1];
      w_guard  = r_q[0];
      w_sticky = (r_rem != 25'h0);
      w_e_adj  = r_exp - 10'sd1;
    end
    w_rnd   = w_guard & (w_sticky | w_m[0]);
    w_m_sum = {1'b0, w_m} + {24'h0, w_rnd};
    if (w_m_sum[24]) begin
      w_m_fin = 24'h800000;
      w_e_fin = w_e_adj + 10'sd1;
    end else begin
      w_m_fin = w_m_sum[23:0];
      w_e_fin = w_e_adj;
    end
    if (w_e_fin >= 10'sd255)
      w_norm_y = {r_sign, 8'hFF, 23'h0};
    else if (w_e_fin <= 10'sd0)
      w_norm_y = {r_sign, 31'h0};
    else
      w_norm_y = {r_sign, w_e_fin[7:0], w_m_fin[22:0]};
  end

  // Specials still pass through one CALC cycle so their result appears one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_sign      <= 1'b0;
      r_exp       <= 10'sd0;
      r_q         <= 26'h0;
      r_rem       <= 25'h0;
      r_mb        <= 24'h0;
      r_spec      <= 1'b0;
      r_spec_y    <= 32'h0;
      r_y         <= 32'h0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign   <= w_sign;
            r_exp    <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]}) + 10'sd127;
            r_rem    <= {2'b01, A[22:0]};
            r_mb     <= {1'b1, B[22:0]};
            r_q      <= 26'h0;
            r_cnt    <= 5'd0;
            r_spec   <= w_spec;
            r_spec_y <= w_spec_y;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_spec) begin
            r_y         <= r_spec_y;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_q   <= {r_q[24:0], w_ge};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd25)
              r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_y         <= w_norm_y;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign Y         = r_y;

endmodule
